// File: rtl/sr_arb_pkg.sv
// Shared definitions for the set/reset flag arbiter.
//   state_t : arbiter FSM states (IDLE, LOCKED)
//   OP_CLR / OP_SET : encoding of a requester's op_set bit
package sr_arb_pkg;

    typedef enum logic {
        IDLE   = 1'b0,
        LOCKED = 1'b1
    } state_t;

    localparam logic OP_CLR = 1'b0;
    localparam logic OP_SET = 1'b1;

endpackage

// File: rtl/rr_pick.sv
// Purely combinational round-robin picker.
// Ports:
//   req    in  NREQ   request vector
//   ptr    in  PTR_W  highest-priority requester index
//   valid  out 1      at least one request present
//   winner out PTR_W  index of the first requester found from ptr upward (mod NREQ)
//   onehot out NREQ   one-hot encoding of winner (all zero when !valid)
module rr_pick #(
    parameter int NREQ  = 4,
    parameter int PTR_W = (NREQ > 1) ? $clog2(NREQ) : 1
) (
    input  logic [NREQ-1:0]  req,
    input  logic [PTR_W-1:0] ptr,
    output logic             valid,
    output logic [PTR_W-1:0] winner,
    output logic [NREQ-1:0]  onehot
);

    logic [PTR_W-1:0] cand;

    always_comb begin
        valid  = 1'b0;
        winner = '0;
        cand   = '0;
        for (int i = 0; i < NREQ; i++) begin
            cand = PTR_W'((int'(ptr) + i) % NREQ);
            if (!valid && req[cand]) begin
                valid  = 1'b1;
                winner = cand;
            end
        end
        onehot = valid ? (NREQ'(1) << winner) : '0;
    end

endmodule

// File: rtl/sr_flag_arbiter.sv
// Shared controller for a bank of set/reset status flags. Requesters issue
// set/clear operations which are serialised, one per cycle, through a
// round-robin arbitrated write port. A requester may lock the port for an
// atomic multi-cycle sequence; the lock is force-released after LOCK_MAX
// cycles.
// Ports:
//   clk        in  1           clock, all state updates on posedge
//   rst        in  1           synchronous active-high reset
//   req        in  NREQ        per-requester operation request
//   op_set     in  NREQ        per-requester op: 1 = set, 0 = clear
//   idx        in  NREQ*IDX_W  per-requester flag index (slice i*IDX_W)
//   lock       in  NREQ        per-requester lock request
//   gnt        out NREQ        one-hot registered grant pulse
//   flags      out NFLAG       registered flag bank
//   locked     out 1           high while in LOCKED
//   lock_abort out 1           one-cycle pulse on timeout release
module sr_flag_arbiter
    import sr_arb_pkg::*;
#(
    parameter int NREQ     = 4,
    parameter int NFLAG    = 8,
    parameter int IDX_W    = $clog2(NFLAG),
    parameter int LOCK_MAX = 16
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [NREQ-1:0]        req,
    input  logic [NREQ-1:0]        op_set,
    input  logic [NREQ*IDX_W-1:0]  idx,
    input  logic [NREQ-1:0]        lock,
    output logic [NREQ-1:0]        gnt,
    output logic [NFLAG-1:0]       flags,
    output logic                   locked,
    output logic                   lock_abort
);

    localparam int PTR_W = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int CNT_W = $clog2(LOCK_MAX + 1);

    state_t             state, state_next;
    logic [PTR_W-1:0]   ptr, ptr_next;
    logic [PTR_W-1:0]   owner, owner_next;
    logic [CNT_W-1:0]   cnt, cnt_next;
    logic [NREQ-1:0]    gnt_next;
    logic [NFLAG-1:0]   flags_next;
    logic               abort_next;

    logic               pick_valid;
    logic [PTR_W-1:0]   pick_winner;
    logic [NREQ-1:0]    pick_onehot;

    logic               exec;
    logic [PTR_W-1:0]   exec_w;
    logic [IDX_W-1:0]   op_idx;

    function automatic logic [PTR_W-1:0] wrap_inc(input logic [PTR_W-1:0] p);
        if (p == PTR_W'(NREQ - 1)) begin
            return '0;
        end
        return p + 1'b1;
    endfunction

    rr_pick #(
        .NREQ  (NREQ),
        .PTR_W (PTR_W)
    ) u_pick (
        .req    (req),
        .ptr    (ptr),
        .valid  (pick_valid),
        .winner (pick_winner),
        .onehot (pick_onehot)
    );

    assign locked = (state == LOCKED);

    // Next-state logic. In IDLE the picker chooses the winner; in LOCKED
    // only the owner is served. Exactly one op (or none) is applied per
    // cycle, so a flag can never see set and clear together.
    always_comb begin
        state_next = state;
        ptr_next   = ptr;
        owner_next = owner;
        cnt_next   = cnt;
        gnt_next   = '0;
        abort_next = 1'b0;
        flags_next = flags;
        exec       = 1'b0;
        exec_w     = '0;
        op_idx     = '0;

        unique case (state)
            IDLE: begin
                if (pick_valid) begin
                    exec     = 1'b1;
                    exec_w   = pick_winner;
                    gnt_next = pick_onehot;
                    ptr_next = wrap_inc(pick_winner);
                    if (lock[pick_winner]) begin
                        state_next = LOCKED;
                        owner_next = pick_winner;
                        cnt_next   = '0;
                    end
                end
            end
            LOCKED: begin
                if (req[owner]) begin
                    exec     = 1'b1;
                    exec_w   = owner;
                    gnt_next = NREQ'(1) << owner;
                end
                cnt_next = cnt + 1'b1;
                // A voluntary release takes precedence over the timeout.
                if (!lock[owner]) begin
                    state_next = IDLE;
                    ptr_next   = wrap_inc(owner);
                    cnt_next   = '0;
                end else if (cnt == CNT_W'(LOCK_MAX - 1)) begin
                    state_next = IDLE;
                    abort_next = 1'b1;
                    ptr_next   = wrap_inc(owner);
                    cnt_next   = '0;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase

        // Out-of-range indices consume the grant but leave the bank alone.
        if (exec) begin
            op_idx = idx[exec_w*IDX_W +: IDX_W];
            if (int'(op_idx) < NFLAG) begin
                flags_next[op_idx] = (op_set[exec_w] == OP_SET);
            end
        end
    end

    // State registers; reset wins over any op in the same cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            ptr        <= '0;
            owner      <= '0;
            cnt        <= '0;
            gnt        <= '0;
            flags      <= '0;
            lock_abort <= 1'b0;
        end else begin
            state      <= state_next;
            ptr        <= ptr_next;
            owner      <= owner_next;
            cnt        <= cnt_next;
            gnt        <= gnt_next;
            flags      <= flags_next;
            lock_abort <= abort_next;
        end
    end

endmodule

// File: tb/tb_sr_flag_arbiter.sv
// Self-checking bench for sr_flag_arbiter: directed scenarios followed by
// randomized traffic, all compared against a behavioural model of the
// arbitration rules.
module tb_sr_flag_arbiter;

    localparam int NREQ     = 4;
    localparam int NFLAG    = 8;
    localparam int IDX_W    = $clog2(NFLAG);
    localparam int LOCK_MAX = 16;

    logic                  clk;
    logic                  rst;
    logic [NREQ-1:0]       req;
    logic [NREQ-1:0]       op_set;
    logic [NREQ*IDX_W-1:0] idx;
    logic [NREQ-1:0]       lock;
    logic [NREQ-1:0]       gnt;
    logic [NFLAG-1:0]      flags;
    logic                  locked;
    logic                  lock_abort;

    int checks = 0;
    int errors = 0;

    // Reference model state
    bit [NFLAG-1:0] m_flags;
    int             m_ptr;
    bit             m_locked;
    int             m_owner;
    int             m_held;
    bit [NREQ-1:0]  exp_gnt;
    bit             exp_abort;

    sr_flag_arbiter #(
        .NREQ     (NREQ),
        .NFLAG    (NFLAG),
        .IDX_W    (IDX_W),
        .LOCK_MAX (LOCK_MAX)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .req        (req),
        .op_set     (op_set),
        .idx        (idx),
        .lock       (lock),
        .gnt        (gnt),
        .flags      (flags),
        .locked     (locked),
        .lock_abort (lock_abort)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    task automatic clear_inputs();
        req    = '0;
        op_set = '0;
        idx    = '0;
        lock   = '0;
    endtask

    task automatic set_req(input int i, input bit op, input int ix, input bit lk);
        req[i]                 = 1'b1;
        op_set[i]              = op;
        idx[i*IDX_W +: IDX_W]  = IDX_W'(ix);
        lock[i]                = lk;
    endtask

    // Apply one requester's op to the model flag bank.
    task automatic model_apply(input int w);
        int ix;
        ix = int'(idx[w*IDX_W +: IDX_W]);
        if (ix < NFLAG) m_flags[ix] = op_set[w];
        exp_gnt = '0;
        exp_gnt[w] = 1'b1;
    endtask

    // Advance the model by one clock using the currently driven inputs.
    task automatic model_cycle();
        exp_gnt   = '0;
        exp_abort = 1'b0;
        if (rst) begin
            m_flags  = '0;
            m_ptr    = 0;
            m_locked = 1'b0;
            m_owner  = 0;
            m_held   = 0;
        end else if (!m_locked) begin
            for (int k = 0; k < NREQ; k++) begin
                int w;
                w = (m_ptr + k) % NREQ;
                if (req[w]) begin
                    model_apply(w);
                    m_ptr = (w + 1) % NREQ;
                    if (lock[w]) begin
                        m_locked = 1'b1;
                        m_owner  = w;
                        m_held   = 0;
                    end
                    break;
                end
            end
        end else begin
            if (req[m_owner]) model_apply(m_owner);
            if (!lock[m_owner]) begin
                m_locked = 1'b0;
                m_ptr    = (m_owner + 1) % NREQ;
            end else if (m_held == LOCK_MAX - 1) begin
                m_locked  = 1'b0;
                exp_abort = 1'b1;
                m_ptr     = (m_owner + 1) % NREQ;
            end else begin
                m_held++;
            end
        end
    endtask

    task automatic check_output();
        check("gnt", 32'(gnt), 32'(exp_gnt));
        check("flags", 32'(flags), 32'(m_flags));
        check("locked", 32'(locked), 32'(m_locked));
        check("lock_abort", 32'(lock_abort), 32'(exp_abort));
    endtask

    // One clock: model update, edge, then sample 1 time unit after the edge.
    task automatic step();
        model_cycle();
        @(posedge clk);
        #1;
        check_output();
    endtask

    task automatic apply_stimulus_random();
        for (int i = 0; i < NREQ; i++) begin
            req[i]                = 1'($urandom_range(0, 1));
            op_set[i]             = 1'($urandom_range(0, 1));
            idx[i*IDX_W +: IDX_W] = IDX_W'($urandom);
            lock[i]               = ($urandom_range(0, 7) == 0);
        end
        if (m_locked) lock[m_owner] = ($urandom_range(0, 9) != 0);
        rst = ($urandom_range(0, 99) == 0);
    endtask

    initial begin
        int aborts;
        int abort_at;

        rst = 1'b1;
        clear_inputs();
        m_flags = '0; m_ptr = 0; m_locked = 1'b0; m_owner = 0; m_held = 0;
        exp_gnt = '0; exp_abort = 1'b0;

        // Reset state
        step();
        step();
        check("rst_gnt", 32'(gnt), 32'h0);
        check("rst_flags", 32'(flags), 32'h0);
        rst = 1'b0;

        // Single uncontested request: req0 sets idx 3
        set_req(0, 1'b1, 3, 1'b0);
        step();
        check("single_gnt", 32'(gnt), 32'h1);
        check("single_flags", 32'(flags), 32'h08);
        clear_inputs();
        // Pointer is now 1: req0 and req1 together -> req1 wins
        set_req(0, 1'b1, 0, 1'b0);
        set_req(1, 1'b1, 1, 1'b0);
        step();
        check("ptr1_gnt", 32'(gnt), 32'h2);
        clear_inputs();

        // All four requesting from pointer 0, each dropping after its grant
        rst = 1'b1;
        step();
        rst = 1'b0;
        for (int i = 0; i < NREQ; i++) set_req(i, 1'b1, i, 1'b0);
        for (int j = 0; j < NREQ; j++) begin
            step();
            check($sformatf("rr_gnt%0d", j), 32'(gnt), 32'(1 << j));
            req[j] = 1'b0;
        end
        check("rr_flags", 32'(flags), 32'h0F);
        clear_inputs();

        // Lock by req1 while req2 waits
        set_req(1, 1'b1, 5, 1'b1);
        set_req(2, 1'b1, 6, 1'b0);
        step();
        check("lk_gnt", 32'(gnt), 32'h2);
        check("lk_locked", 32'(locked), 32'h1);
        check("lk_flag5", 32'(flags[5]), 32'h1);
        req[1] = 1'b0;
        step();
        check("lk_wait_gnt", 32'(gnt), 32'h0);
        set_req(1, 1'b0, 5, 1'b0);
        step();
        check("lk_final_gnt", 32'(gnt), 32'h2);
        check("lk_flag5_clr", 32'(flags[5]), 32'h0);
        check("lk_unlocked", 32'(locked), 32'h0);
        req[1] = 1'b0;
        step();
        check("lk_req2_gnt", 32'(gnt), 32'h4);
        clear_inputs();

        // Timeout: req2 keeps lock high past LOCK_MAX
        set_req(2, 1'b1, 2, 1'b1);
        step();
        check("to_locked", 32'(locked), 32'h1);
        req[2] = 1'b0;
        aborts = 0;
        abort_at = 0;
        for (int k = 1; k <= LOCK_MAX + 2; k++) begin
            step();
            if (lock_abort === 1'b1) begin
                aborts++;
                abort_at = k;
            end
        end
        check("to_abort_count", 32'(aborts), 32'd1);
        check("to_abort_cycle", 32'(abort_at), 32'(LOCK_MAX));
        check("to_unlocked", 32'(locked), 32'h0);
        clear_inputs();
        // Pointer should now be 3
        set_req(0, 1'b1, 0, 1'b0);
        set_req(3, 1'b1, 4, 1'b0);
        step();
        check("to_ptr3_gnt", 32'(gnt), 32'h8);
        clear_inputs();

        // Set twice then clear the same flag on consecutive grants
        set_req(0, 1'b1, 7, 1'b0);
        step();
        step();
        check("sc_set", 32'(flags[7]), 32'h1);
        op_set[0] = 1'b0;
        step();
        check("sc_clr", 32'(flags[7]), 32'h0);
        check("sc_no_x", 32'($isunknown(flags)), 32'h0);
        clear_inputs();

        // Reset while locked with an active request
        set_req(3, 1'b1, 1, 1'b1);
        step();
        check("rl_locked", 32'(locked), 32'h1);
        set_req(3, 1'b1, 4, 1'b1);
        rst = 1'b1;
        step();
        check("rl_gnt", 32'(gnt), 32'h0);
        check("rl_flags", 32'(flags), 32'h0);
        check("rl_locked0", 32'(locked), 32'h0);
        check("rl_abort0", 32'(lock_abort), 32'h0);
        rst = 1'b0;
        clear_inputs();
        step();

        // Randomized traffic against the model
        for (int n = 0; n < 400; n++) begin
            apply_stimulus_random();
            step();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/sr_flag_arbiter.md
# sr_flag_arbiter

Shared controller for a bank of set/reset status flags. Several requesters each issue set or clear operations on a single flag, and the block serialises them through one round-robin-arbitrated write port. Because exactly one operation is applied per cycle, the S&R-simultaneous (X) case of a bare SR flip-flop can never occur. An optional lock lets one requester perform an atomic multi-cycle sequence, bounded by a timeout.

## Interface
Parameters:
- NREQ, 4: number of requesters (≥2)
- NFLAG, 8: number of flag bits
- IDX_W, $clog2(NFLAG): flag index width
- LOCK_MAX, 16: maximum cycles a lock may be held before forced release

Ports:
- clk  in  1  single clock, all state updates on posedge
- rst  in  1  synchronous, active-high reset
- req  in  NREQ  per-requester operation request
- op_set  in  NREQ  per-requester op: 1 = set flag, 0 = clear flag
- idx  in  NREQ*IDX_W  per-requester flag index, requester i at bits [i*IDX_W +: IDX_W]
- lock  in  NREQ  per-requester lock request; sampled with req
- gnt  out  NREQ  one-hot, registered; pulse marks the cycle an op took effect
- flags  out  NFLAG  registered flag bank
- locked  out  1  high while FSM is in LOCKED
- lock_abort  out  1  one-cycle pulse when a lock is force-released by timeout

## Operation
- Reset: flags=0, gnt=0, locked=0, lock_abort=0, rr pointer=0, lock counter=0, FSM=IDLE, owner=0.
- FSM states: IDLE, LOCKED.
- IDLE:
  - Winner is the first requester with req=1, searching from the rr pointer upward mod NREQ.
  - On a win at edge t:
    - gnt[w]=1.
    - flags[idx_w] is set (op_set=1) or cleared (op_set=0); other flags unchanged.
    - Pointer becomes (w+1) mod NREQ.
  - If lock[w]=1: FSM goes to LOCKED, owner=w, counter=0.
- LOCKED:
  - Only req[owner] is considered; all other requests wait with gnt held at 0.
  - If req[owner]=1, the op executes with gnt[owner]=1.
  - If lock[owner]=0 is sampled, FSM returns to IDLE at that edge. An accompanying req is still executed as the final op.
  - Counter increments every cycle in LOCKED. If the counter reaches LOCK_MAX-1 while lock[owner] is still 1:
    - FSM goes to IDLE and lock_abort pulses.
    - An owner op in that cycle is still executed.
    - The pointer becomes owner+1.
- The pointer is not updated by grants inside LOCKED, except on exit.
- Out-of-range idx (≥NFLAG) still consumes the grant; flags stay unchanged.
- A requester holds req until it sees gnt. If req is still high in the cycle after gnt, that is a new request.
- With no req in IDLE: gnt=0 and nothing else changes.

## Timing
- Latency for an uncontested request: req sampled at edge t, gnt and updated flags visible after edge t (same cycle as gnt), i.e. one clock.
- gnt is a single-cycle pulse per executed op. Back-to-back grants to different requesters occur on consecutive cycles.
- All NREQ requesters held high are each served once within NREQ cycles.
- rst during LOCKED: the same-edge reset wins. All state returns to reset values, no op executes, and lock_abort stays 0.
- lock_abort and the FSM return to IDLE occur at the same edge.

## Structure
- Package sr_arb_pkg:
  - State enum {IDLE, LOCKED}.
  - Op encoding constants (OP_CLR=0, OP_SET=1).
- Sub-module rr_pick: purely combinational round-robin picker.
  - Inputs: req vector, pointer.
  - Outputs: valid, winner index, one-hot.
- Top level holds the FSM, pointer, owner, lock counter and flag register.

## Test plan
- Reset, then req0 (set idx 3) alone → next cycle gnt=0001, flags=0x08; rr pointer=1.
- req0..3 all high, each setting idx=i, pointer 0 → gnt sequence 0001, 0010, 0100, 1000 on four consecutive cycles; flags=0x0F.
- req1 with lock=1 (set idx 5), then req1 clear idx 5 with lock=0, while req2 is held high throughout:
  - req2 gets no gnt while locked.
  - flags[5] goes 1 → 0; locked drops and req2 is granted on the following cycle.
- req2 locks and keeps lock=1 for LOCK_MAX+2 cycles → lock_abort pulses once after LOCK_MAX cycles in LOCKED; locked=0; pointer=3.
- Flag already set; requester set-then-clear on the same idx in consecutive grants → no X on flags; final value 0.
- Assert rst while locked with req active → next cycle all outputs 0, FSM IDLE; the op is not applied.
